ptp_bridge_avmm_rsp_agg: RTL and testbench
==========================================

PTP_BRIDGE_AVMM_RSP_AGG -- requirements
Module: ptp_bridge_avmm_rsp_agg

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 2: number of downstream register regions returning read responses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: read data width.
REQ-003 SHALL have parameter MAX_PENDING, default 4: outstanding host reads, power of two, >= 2.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64: head-of-queue wait limit before a synthetic response is issued.
REQ-005 SHALL have parameter DEFAULT_RDATA, default 'hDEAD_BEEF: data returned for unmapped or timed-out reads.
REQ-006 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port avmm_read  in  1  host read request.
REQ-009 SHALL have port avmm_waitrequest  out  1  back-pressure to host; asserted while the tag queue is full.
REQ-010 SHALL have port rgn_hit  in  NUM_REGIONS  one bit per region, sampled with avmm_read; region k's decoder claims the address.
REQ-011 SHALL have port rgn_readdata  in  NUM_REGIONS x DATA_WIDTH  per-region read data.
REQ-012 SHALL have port rgn_readdatavalid  in  NUM_REGIONS  per-region read-data strobe.
REQ-013 SHALL have port avmm_readdata  out  DATA_WIDTH  aggregated read data to host.
REQ-014 SHALL have port avmm_readdatavalid  out  1  one-cycle strobe qualifying avmm_readdata.
REQ-015 SHALL have port err_clr  in  1  clears the sticky error flags.
REQ-016 SHALL have port timeout_err  out  1  sticky; at least one read timed out.
REQ-017 SHALL have port spurious_err  out  1  sticky; a region strobed data while it was not at queue head.

Function
REQ-018 SHALL accept a read when avmm_read=1 and avmm_waitrequest=0, pushing a tag into an in-order queue; writes are not tracked.
REQ-019 SHALL encode the tag as the lowest set index of rgn_hit, or UNMAPPED when rgn_hit=0; multi-hot resolves to the lowest index.
REQ-020 SHALL drive avmm_waitrequest = (occupancy == MAX_PENDING) combinationally from registered occupancy; a pop in the same cycle does not release it.
REQ-021 SHALL make a pushed tag visible at queue head no earlier than the cycle after the push.
REQ-022 SHALL, when the head tag is region k and rgn_readdatavalid[k]=1 at cycle t, register rgn_readdata[k] to avmm_readdata with avmm_readdatavalid=1 at t+1, and pop the head.
REQ-023 SHALL, when the head tag is UNMAPPED at cycle t, output DEFAULT_RDATA with avmm_readdatavalid=1 at t+1 and pop the head.
REQ-024 SHALL run a head wait counter that clears on every pop and increments each cycle a mapped head waits.
REQ-025 SHALL, when the counter reaches TIMEOUT_CYCLES, output DEFAULT_RDATA with avmm_readdatavalid=1 the next cycle, pop the head and set timeout_err.
REQ-026 SHALL treat timed-out responses as lost; a late strobe from that region is attributed to the current head if it is the same region, otherwise it is handled per REQ-027.
REQ-027 SHALL discard any rgn_readdatavalid[j]=1 where j is not the head region or the queue is empty, and set spurious_err.
REQ-028 SHALL pop at most one tag per cycle; push and pop in the same cycle leave occupancy unchanged.
REQ-029 SHALL drive avmm_readdatavalid=0 in all cycles without a pop; avmm_readdata holds its last value.
REQ-030 SHALL have err_clr clear both flags; a set in the same cycle wins.

Reset
REQ-031 SHALL, on rst=1, empty the queue, clear the counter, and drive avmm_readdatavalid=0, avmm_readdata=0, timeout_err=0 and spurious_err=0 the following cycle.
REQ-032 SHALL drop reads outstanding at reset silently; post-reset strobes on an empty queue set spurious_err.
REQ-033 SHALL hold avmm_waitrequest=0 during and after reset.

Structure
REQ-034 SHALL place the tag typedef (region index plus UNMAPPED encoding) and the DEFAULT_RDATA default in package ptp_bridge_avmm_pkg.
REQ-035 SHALL implement the tag queue as sub-module ptp_bridge_avmm_tag_fifo (synchronous FIFO, MAX_PENDING deep, registered occupancy).

Verification
REQ-036 SHALL cover the mapped path: read with rgn_hit=2'b10, rgn_readdatavalid[1] with 'h1234 three cycles later -> avmm_readdata='h1234 and avmm_readdatavalid=1 exactly one cycle after the strobe.
REQ-037 SHALL cover the unmapped path: read with rgn_hit=0 -> 'hDEAD_BEEF returned, no error flag set.
REQ-038 SHALL cover back-pressure: 4 back-to-back reads with no responses -> avmm_waitrequest=1 from the cycle after the 4th accept; one response -> waitrequest deasserts the cycle after the pop.
REQ-039 SHALL cover timeout: TIMEOUT_CYCLES=8, region 0 silent -> 'hDEAD_BEEF returned after 8 wait cycles and timeout_err=1; err_clr -> timeout_err=0.
REQ-040 SHALL cover ordering and spurious strobes: reads to region 0 then region 1, region 1 strobes first -> data discarded, spurious_err=1, and region 0's data returned once it responds.
REQ-041 SHALL cover reset mid-operation: rst with 3 reads pending -> all outputs 0 the next cycle, and the next read completes normally.

Source files
------------

// File: rtl/ptp_bridge_avmm_pkg.sv
// Shared types for the AVMM read-response aggregator: response tag encoding,
// default read data and the hit-vector to tag encoder.
package ptp_bridge_avmm_pkg;

  localparam int unsigned RGN_IDX_W   = 7;
  localparam int unsigned MAX_REGIONS = 1 << RGN_IDX_W;

  localparam logic [31:0] DEFAULT_RDATA_C = 32'hDEAD_BEEF;

  typedef struct packed {
    logic                 unmapped;
    logic [RGN_IDX_W-1:0] idx;
  } tag_t;

  localparam tag_t TAG_UNMAPPED = '{unmapped: 1'b1, idx: {RGN_IDX_W{1'b0}}};

  // Scanning downward lets the lowest set bit overwrite any higher one.
  function automatic tag_t encode_tag(input logic [MAX_REGIONS-1:0] hit);
    tag_t tag;
    tag = TAG_UNMAPPED;
    for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        tag.unmapped = 1'b0;
        tag.idx      = RGN_IDX_W'(i);
      end
    end
    return tag;
  endfunction

endpackage

// File: rtl/ptp_bridge_avmm_rsp_agg_if.sv
// Host read handshake plus per-region response bundle of the aggregator.
interface ptp_bridge_avmm_rsp_agg_if #(
  parameter int unsigned NUM_REGIONS = 2,
  parameter int unsigned DATA_WIDTH  = 32
);
  logic                                   avmm_read;
  logic                                   avmm_waitrequest;
  logic [NUM_REGIONS-1:0]                 rgn_hit;
  logic [NUM_REGIONS-1:0][DATA_WIDTH-1:0] rgn_readdata;
  logic [NUM_REGIONS-1:0]                 rgn_readdatavalid;
  logic [DATA_WIDTH-1:0]                  avmm_readdata;
  logic                                   avmm_readdatavalid;

  modport master (
    output avmm_read, rgn_hit, rgn_readdata, rgn_readdatavalid,
    input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid
  );

  modport slave (
    input  avmm_read, rgn_hit, rgn_readdata, rgn_readdatavalid,
    output avmm_waitrequest, avmm_readdata, avmm_readdatavalid
  );
endinterface

// File: rtl/ptp_bridge_avmm_tag_fifo.sv
// In-order tag queue: synchronous FIFO with registered occupancy; a pushed
// tag reaches the head output no earlier than the following cycle.
module ptp_bridge_avmm_tag_fifo
  import ptp_bridge_avmm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  tag_t push_tag_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output tag_t head_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  tag_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == CNT_W'(0));
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      cnt_q    <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_tag_i;
    end
  end

endmodule

// File: rtl/ptp_bridge_avmm_rsp_agg.sv
// Aggregates per-region read responses back to the host in request order,
// synthesising DEFAULT_RDATA for unmapped and timed-out reads.
module ptp_bridge_avmm_rsp_agg
  import ptp_bridge_avmm_pkg::*;
#(
  parameter int unsigned           NUM_REGIONS    = 2,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           MAX_PENDING    = 4,
  parameter int unsigned           TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA  = DATA_WIDTH'(DEFAULT_RDATA_C)
) (
  input  logic                      clk,
  input  logic                      rst,
  ptp_bridge_avmm_rsp_agg_if.slave  bus,
  input  logic                      err_clr,
  output logic                      timeout_err,
  output logic                      spurious_err
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [MAX_REGIONS-1:0] hit_ext_s;
  tag_t                   push_tag_s, head_s;
  logic                   accept_s, full_s, empty_s;
  logic                   head_mapped_s, hit_s, spur_s, tmo_s, pop_s;
  logic [NUM_REGIONS-1:0] own_s;
  logic [DATA_WIDTH-1:0]  hit_data_s;

  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rdv_q, rdv_d, terr_q, terr_d, serr_q, serr_d;

  always_comb begin
    hit_ext_s                  = {MAX_REGIONS{1'b0}};
    hit_ext_s[NUM_REGIONS-1:0] = bus.rgn_hit;
  end

  assign push_tag_s           = encode_tag(hit_ext_s);
  assign bus.avmm_waitrequest = full_s & ~rst;
  assign accept_s             = bus.avmm_read & ~bus.avmm_waitrequest;

  ptp_bridge_avmm_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept_s),
    .push_tag_i (push_tag_s),
    .pop_i      (pop_s),
    .full_o     (full_s),
    .empty_o    (empty_s),
    .head_o     (head_s)
  );

  // A strobe is owned only by the region at a mapped queue head; any other strobe is spurious.
  always_comb begin
    head_mapped_s = ~empty_s & ~head_s.unmapped;
    hit_data_s    = {DATA_WIDTH{1'b0}};
    for (int j = 0; j < NUM_REGIONS; j++) begin
      own_s[j]   = head_mapped_s & (head_s.idx == RGN_IDX_W'(j));
      hit_data_s = (bus.rgn_readdatavalid[j] & own_s[j]) ? bus.rgn_readdata[j] : hit_data_s;
    end
    hit_s  = |(bus.rgn_readdatavalid & own_s);
    spur_s = |(bus.rgn_readdatavalid & ~own_s);
    tmo_s  = head_mapped_s & ~hit_s & (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    pop_s  = (~empty_s & head_s.unmapped) | hit_s | tmo_s;
  end

  // Response, wait-counter and sticky-flag next state; a flag set beats err_clr.
  always_comb begin
    if (pop_s || !head_mapped_s) begin
      wait_cnt_d = CNT_W'(0);
    end else begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    rdv_d   = pop_s;
    rdata_d = hit_s ? hit_data_s : (pop_s ? DEFAULT_RDATA : rdata_q);
    terr_d  = tmo_s  | (terr_q & ~err_clr);
    serr_d  = spur_s | (serr_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= CNT_W'(0);
      rdata_q    <= {DATA_WIDTH{1'b0}};
      rdv_q      <= 1'b0;
      terr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      rdv_q      <= rdv_d;
      terr_q     <= terr_d;
      serr_q     <= serr_d;
    end
  end

  assign bus.avmm_readdata      = rdata_q;
  assign bus.avmm_readdatavalid = rdv_q;
  assign timeout_err            = terr_q;
  assign spurious_err           = serr_q;

endmodule

// File: tb/tb_ptp_bridge_avmm_rsp_agg.sv
// Directed scenarios followed by random traffic, every cycle checked against
// a queue-based behavioural model of the aggregator.
module tb_ptp_bridge_avmm_rsp_agg;
  localparam int          NR  = 2;
  localparam int          DW  = 32;
  localparam int          MP  = 4;
  localparam int          TO  = 8;
  localparam logic [31:0] DEF = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst, err_clr, timeout_err, spurious_err;

  ptp_bridge_avmm_rsp_agg_if #(.NUM_REGIONS(NR), .DATA_WIDTH(DW)) bus ();

  ptp_bridge_avmm_rsp_agg #(
    .NUM_REGIONS    (NR),
    .DATA_WIDTH     (DW),
    .MAX_PENDING    (MP),
    .TIMEOUT_CYCLES (TO),
    .DEFAULT_RDATA  (DEF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .err_clr      (err_clr),
    .timeout_err  (timeout_err),
    .spurious_err (spurious_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: outstanding reads as region numbers (-1 = unmapped).
  int          q[$];
  int          age;
  logic        e_rdv;
  logic [31:0] e_rdata;
  logic        e_terr, e_serr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int tag_of(input logic [NR-1:0] h);
    for (int i = 0; i < NR; i++) begin
      if (h[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit          pop, tmo, spur, accept;
    logic [31:0] d;
    pop = 0; tmo = 0; spur = 0;
    d = e_rdata;
    if (rst) begin
      q.delete();
      age = 0; e_rdv = 1'b0; e_rdata = 32'h0; e_terr = 1'b0; e_serr = 1'b0;
      return;
    end
    accept = bus.avmm_read && (q.size() != MP);
    if (q.size() > 0) begin
      if (q[0] < 0) begin
        pop = 1; d = DEF;
      end else if (bus.rgn_readdatavalid[q[0]]) begin
        pop = 1; d = bus.rgn_readdata[q[0]];
      end else if (age == TO) begin
        pop = 1; tmo = 1; d = DEF;
      end else begin
        age++;
      end
    end
    for (int j = 0; j < NR; j++) begin
      if (bus.rgn_readdatavalid[j] && !(q.size() > 0 && q[0] == j)) spur = 1;
    end
    e_terr = tmo  | (e_terr & !err_clr);
    e_serr = spur | (e_serr & !err_clr);
    if (pop) begin
      void'(q.pop_front());
      age = 0;
    end
    e_rdv   = pop;
    e_rdata = d;
    if (accept) q.push_back(tag_of(bus.rgn_hit));
  endtask

  // One clock: check waitrequest, advance model, then check registered outputs.
  task automatic cycle();
    #1;
    chk("waitreq", {31'b0, bus.avmm_waitrequest}, {31'b0, (q.size() == MP) && !rst});
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("rdv",   {31'b0, bus.avmm_readdatavalid}, {31'b0, e_rdv});
    chk("rdata", bus.avmm_readdata, e_rdata);
    chk("terr",  {31'b0, timeout_err}, {31'b0, e_terr});
    chk("serr",  {31'b0, spurious_err}, {31'b0, e_serr});
  endtask

  task automatic quiet();
    rst = 1'b0;
    err_clr = 1'b0;
    bus.avmm_read = 1'b0;
    bus.rgn_hit = 2'b00;
    bus.rgn_readdatavalid = 2'b00;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    bus.rgn_readdata = '0;
    q.delete();
    age = 0; e_rdv = 1'b0; e_rdata = 32'h0; e_terr = 1'b0; e_serr = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_rdata", bus.avmm_readdata, 32'h0);
    chk("rst_rdv",   {31'b0, bus.avmm_readdatavalid}, 32'h0);
    chk("rst_wr",    {31'b0, bus.avmm_waitrequest}, 32'h0);
    chk("rst_terr",  {31'b0, timeout_err}, 32'h0);

    // Mapped path: region 1, strobe three cycles after accept.
    quiet(); bus.avmm_read = 1'b1; bus.rgn_hit = 2'b10; cycle();
    quiet(); cycle(); cycle();
    chk("map_early", {31'b0, bus.avmm_readdatavalid}, 32'h0);
    bus.rgn_readdatavalid = 2'b10; bus.rgn_readdata[1] = 32'h1234; cycle();
    chk("map_data", bus.avmm_readdata, 32'h1234);
    chk("map_rdv",  {31'b0, bus.avmm_readdatavalid}, 32'h1);

    // Unmapped path.
    quiet(); bus.avmm_read = 1'b1; bus.rgn_hit = 2'b00; cycle();
    quiet(); cycle();
    chk("unm_data", bus.avmm_readdata, DEF);
    chk("unm_rdv",  {31'b0, bus.avmm_readdatavalid}, 32'h1);
    chk("unm_serr", {31'b0, spurious_err}, 32'h0);
    chk("unm_terr", {31'b0, timeout_err}, 32'h0);

    // Back-pressure: four reads fill the queue.
    for (int i = 0; i < 4; i++) begin
      quiet(); bus.avmm_read = 1'b1; bus.rgn_hit = 2'b01; cycle();
    end
    chk("bp_full", {31'b0, bus.avmm_waitrequest}, 32'h1);
    cycle();
    quiet(); bus.rgn_readdatavalid = 2'b01; bus.rgn_readdata[0] = 32'h5;
    chk("bp_hold", {31'b0, bus.avmm_waitrequest}, 32'h1);
    cycle();
    chk("bp_data", bus.avmm_readdata, 32'h5);
    quiet();
    chk("bp_release", {31'b0, bus.avmm_waitrequest}, 32'h0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      quiet(); bus.rgn_readdatavalid = 2'b01; bus.rgn_readdata[0] = 32'h6 + i; cycle();
    end
    chk("bp_drain", bus.avmm_readdata, 32'h8);

    // Timeout: region 0 silent for TO wait cycles.
    quiet(); bus.avmm_read = 1'b1; bus.rgn_hit = 2'b01; cycle();
    quiet();
    for (int i = 0; i < TO; i++) cycle();
    chk("to_early", {31'b0, bus.avmm_readdatavalid}, 32'h0);
    cycle();
    chk("to_data", bus.avmm_readdata, DEF);
    chk("to_rdv",  {31'b0, bus.avmm_readdatavalid}, 32'h1);
    chk("to_err",  {31'b0, timeout_err}, 32'h1);
    bus.rgn_readdatavalid = 2'b01; bus.rgn_readdata[0] = 32'h77; cycle();
    chk("late_spur", {31'b0, spurious_err}, 32'h1);
    chk("late_data", bus.avmm_readdata, DEF);
    quiet(); err_clr = 1'b1; cycle();
    chk("clr_terr", {31'b0, timeout_err}, 32'h0);
    chk("clr_serr", {31'b0, spurious_err}, 32'h0);

    // Ordering: region 1 answers before region 0.
    quiet(); bus.avmm_read = 1'b1; bus.rgn_hit = 2'b01; cycle();
    bus.rgn_hit = 2'b10; cycle();
    quiet(); bus.rgn_readdatavalid = 2'b10; bus.rgn_readdata[1] = 32'hAAAA; cycle();
    chk("ord_disc", {31'b0, bus.avmm_readdatavalid}, 32'h0);
    chk("ord_spur", {31'b0, spurious_err}, 32'h1);
    quiet(); bus.rgn_readdatavalid = 2'b01; bus.rgn_readdata[0] = 32'hBBBB; cycle();
    chk("ord_data0", bus.avmm_readdata, 32'hBBBB);
    quiet(); bus.rgn_readdatavalid = 2'b10; bus.rgn_readdata[1] = 32'hCCCC; cycle();
    chk("ord_data1", bus.avmm_readdata, 32'hCCCC);

    // Reset with three reads pending (spurious_err still set).
    for (int i = 0; i < 3; i++) begin
      quiet(); bus.avmm_read = 1'b1; bus.rgn_hit = (i == 1) ? 2'b10 : 2'b11; cycle();
    end
    quiet(); rst = 1'b1; cycle();
    chk("mrst_rdata", bus.avmm_readdata, 32'h0);
    chk("mrst_rdv",   {31'b0, bus.avmm_readdatavalid}, 32'h0);
    chk("mrst_serr",  {31'b0, spurious_err}, 32'h0);
    chk("mrst_wr",    {31'b0, bus.avmm_waitrequest}, 32'h0);
    quiet(); bus.avmm_read = 1'b1; bus.rgn_hit = 2'b10; cycle();
    quiet(); bus.rgn_readdatavalid = 2'b10; bus.rgn_readdata[1] = 32'h7777; cycle();
    chk("post_data", bus.avmm_readdata, 32'h7777);
    chk("post_serr", {31'b0, spurious_err}, 32'h0);
    quiet(); bus.rgn_readdatavalid = 2'b01; cycle();
    chk("post_empty_spur", {31'b0, spurious_err}, 32'h1);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      bus.avmm_read = 1'($urandom_range(0, 1));
      bus.rgn_hit   = 2'($urandom_range(0, 3));
      for (int j = 0; j < NR; j++) begin
        bus.rgn_readdatavalid[j] = ($urandom_range(0, 3) == 0);
        bus.rgn_readdata[j]      = $urandom;
      end
      err_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
